gate_actuator: RTL and testbench

GATE_ACTUATOR -- requirements
Module: gate_actuator

---
 rtl/gate_actuator.sv | 126 ++++++++++++
 tb/tb_gate_actuator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_actuator.sv
// Gate actuator: five-state travel controller with interlock and obstruction handling.
// Position counts cycles of travel from 0 (closed) up to TRAVEL (open).
module gate_actuator #(
    parameter int TRAVEL = 8,
    parameter int CW     = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          OpenClose,
    input  logic          Interlock,
    input  logic          Obstruct,
    output logic          MotorUp,
    output logic          MotorDown,
    output logic          GateOpen,
    output logic          GateClosed,
    output logic [CW-1:0] Position,
    output logic          Done,
    output logic          Blocked
);

    typedef enum logic [2:0] {
        S_CLOSED,
        S_OPENING,
        S_OPEN,
        S_CLOSING,
        S_HALT
    } state_t;

    localparam logic [CW-1:0] POS_TOP = CW'(TRAVEL);
    localparam logic [CW-1:0] POS_PRE = CW'(TRAVEL - 1);
    localparam logic [CW-1:0] POS_ONE = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] pos_q, pos_d;
    logic          done_q, done_d;
    logic          up_q, up_d;
    logic          dn_q, dn_d;
    logic          open_q, open_d;
    logic          closed_q, closed_d;
    logic          open_req;

    assign open_req = OpenClose && !Interlock;

    // Range guards (>= / <=) keep Position inside 0..TRAVEL after reversals.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        unique case (state_q)
            S_CLOSED: begin
                if (open_req) state_d = S_OPENING;
            end
            S_OPENING: begin
                if (!open_req) begin
                    state_d = S_CLOSING;
                end else if (pos_q >= POS_PRE) begin
                    pos_d   = POS_TOP;
                    state_d = S_OPEN;
                end else begin
                    pos_d = pos_q + POS_ONE;
                end
            end
            S_OPEN: begin
                if (!open_req) state_d = S_CLOSING;
            end
            S_CLOSING: begin
                if (open_req) begin
                    state_d = S_OPENING;
                end else if (Obstruct) begin
                    state_d = S_HALT;
                end else if (pos_q <= POS_ONE) begin
                    pos_d   = '0;
                    state_d = S_CLOSED;
                end else begin
                    pos_d = pos_q - POS_ONE;
                end
            end
            S_HALT: begin
                if (Obstruct)      state_d = S_HALT;
                else if (open_req) state_d = S_OPENING;
                else               state_d = S_CLOSING;
            end
            default: begin
                state_d = S_CLOSED;
                pos_d   = '0;
            end
        endcase
    end

    always_comb begin
        done_d   = ((state_d == S_OPEN) && (state_q != S_OPEN)) ||
                   ((state_d == S_CLOSED) && (state_q != S_CLOSED));
        up_d     = (state_d == S_OPENING);
        dn_d     = (state_d == S_CLOSING);
        open_d   = (state_d == S_OPEN);
        closed_d = (state_d == S_CLOSED);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_CLOSED;
            pos_q    <= '0;
            done_q   <= 1'b0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            open_q   <= 1'b0;
            closed_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            done_q   <= done_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            open_q   <= open_d;
            closed_q <= closed_d;
        end
    end

    assign MotorUp    = up_q;
    assign MotorDown  = dn_q;
    assign GateOpen   = open_q;
    assign GateClosed = closed_q;
    assign Position   = pos_q;
    assign Done       = done_q;
    assign Blocked    = (state_q == S_CLOSED) && OpenClose && Interlock;

endmodule

// File: tb/tb_gate_actuator.sv
// Directed bench for gate_actuator with TRAVEL=4.
// Observed vector: {up,down,open,closed,done,blocked,position}.
module tb_gate_actuator;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       OpenClose = 1'b0;
    logic       Interlock = 1'b0;
    logic       Obstruct = 1'b0;
    logic       MotorUp, MotorDown, GateOpen, GateClosed, Done, Blocked;
    logic [3:0] Position;
    logic [9:0] obs;

    int errors = 0;
    int checks = 0;

    gate_actuator #(.TRAVEL(4), .CW(4)) dut (
        .Clock(Clock), .Reset(Reset), .OpenClose(OpenClose),
        .Interlock(Interlock), .Obstruct(Obstruct),
        .MotorUp(MotorUp), .MotorDown(MotorDown),
        .GateOpen(GateOpen), .GateClosed(GateClosed),
        .Position(Position), .Done(Done), .Blocked(Blocked)
    );

    always #5 Clock = ~Clock;

    assign obs = {MotorUp, MotorDown, GateOpen, GateClosed, Done, Blocked, Position};

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_reset();
        OpenClose = 1'b0;
        Interlock = 1'b0;
        Obstruct  = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (obs !== {6'b000100, 4'd0}) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", obs, {6'b000100, 4'd0});
        end
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_open();
        logic [9:0] e;
        OpenClose = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            e = (i == 5) ? {6'b001010, 4'd4} : {6'b100000, 4'(i - 1)};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL open_edge%0d got %b exp %b", i, obs, e);
            end
        end
        tick();
        checks++;
        if (obs !== {6'b001000, 4'd4}) begin
            errors++;
            $display("FAIL open_done_clear got %b exp %b", obs, {6'b001000, 4'd4});
        end
    endtask

    task automatic test_close();
        logic [9:0] e;
        OpenClose = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i <= 4)      e = {6'b010000, 4'(5 - i)};
            else if (i == 5) e = {6'b000110, 4'd0};
            else             e = {6'b000100, 4'd0};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL close_edge%0d got %b exp %b", i, obs, e);
            end
        end
    endtask

    task automatic test_reversal();
        logic [9:0] exp_t [7];
        int         done_cnt;
        exp_t = '{{6'b100000, 4'd0}, {6'b100000, 4'd1}, {6'b100000, 4'd2},
                  {6'b010000, 4'd2}, {6'b010000, 4'd1}, {6'b000110, 4'd0},
                  {6'b000100, 4'd0}};
        done_cnt = 0;
        apply_reset();
        OpenClose = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) OpenClose = 1'b0;
            tick();
            if (Done) done_cnt++;
            checks++;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL reversal_step%0d got %b exp %b", i, obs, exp_t[i]);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL reversal_done_count got %0d exp 1", done_cnt);
        end
    endtask

    task automatic test_interlock();
        apply_reset();
        OpenClose = 1'b1;
        Interlock = 1'b1;
        #1;
        checks++;
        if (obs !== {6'b000101, 4'd0}) begin
            errors++;
            $display("FAIL blocked_comb got %b exp %b", obs, {6'b000101, 4'd0});
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (obs !== {6'b000101, 4'd0}) begin
                errors++;
                $display("FAIL blocked_hold%0d got %b exp %b", i, obs, {6'b000101, 4'd0});
            end
        end
        Interlock = 1'b0;
        #1;
        checks++;
        if (obs !== {6'b000100, 4'd0}) begin
            errors++;
            $display("FAIL unblocked got %b exp %b", obs, {6'b000100, 4'd0});
        end
        tick();
        checks++;
        if (obs !== {6'b100000, 4'd0}) begin
            errors++;
            $display("FAIL unblocked_open got %b exp %b", obs, {6'b100000, 4'd0});
        end
    endtask

    task automatic test_interlock_open();
        logic [9:0] exp_t [5];
        exp_t = '{{6'b100000, 4'd0}, {6'b100000, 4'd1}, {6'b100000, 4'd2},
                  {6'b010000, 4'd2}, {6'b010000, 4'd1}};
        apply_reset();
        OpenClose = 1'b1;
        Obstruct  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                Interlock = 1'b1;
                Obstruct  = 1'b0;
            end
            tick();
            checks++;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL intlk_open_step%0d got %b exp %b", i, obs, exp_t[i]);
            end
        end
    endtask

    task automatic test_obstruct();
        logic [9:0] exp_t [13];
        exp_t = '{{6'b100000, 4'd0}, {6'b100000, 4'd1}, {6'b100000, 4'd2},
                  {6'b100000, 4'd3}, {6'b001010, 4'd4}, {6'b010000, 4'd4},
                  {6'b010000, 4'd3}, {6'b000000, 4'd3}, {6'b000000, 4'd3},
                  {6'b010000, 4'd3}, {6'b010000, 4'd2}, {6'b010000, 4'd1},
                  {6'b000110, 4'd0}};
        apply_reset();
        OpenClose = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 5) OpenClose = 1'b0;
            if (i == 7) Obstruct = 1'b1;
            if (i == 9) Obstruct = 1'b0;
            tick();
            if (i >= 4) begin
                checks++;
                if (obs !== exp_t[i]) begin
                    errors++;
                    $display("FAIL obstruct_step%0d got %b exp %b", i, obs, exp_t[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        OpenClose = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (obs !== {6'b100000, 4'd3}) begin
            errors++;
            $display("FAIL areset_pre got %b exp %b", obs, {6'b100000, 4'd3});
        end
        #3 Reset = 1'b0;
        #1;
        checks++;
        if (obs !== {6'b000100, 4'd0}) begin
            errors++;
            $display("FAIL areset_immediate got %b exp %b", obs, {6'b000100, 4'd0});
        end
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (obs !== {6'b000100, 4'd0}) begin
                errors++;
                $display("FAIL areset_hold%0d got %b exp %b", i, obs, {6'b000100, 4'd0});
            end
        end
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        checks++;
        if (obs !== {6'b100000, 4'd0}) begin
            errors++;
            $display("FAIL areset_release got %b exp %b", obs, {6'b100000, 4'd0});
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_close();
        test_reversal();
        test_interlock();
        test_interlock_open();
        test_obstruct();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
